selection_sort_stream_core: RTL and testbench
=============================================

Name: selection_sort_stream_core

Overview:
Parametrised selection-sort engine, successor to the fixed 4-register AXI4-Lite sort IP. Accepts a frame of up to DEPTH words on an AXI4-Stream slave, sorts in place (ascending or descending, signed or unsigned), then emits the sorted frame on an AXI4-Stream master. Sits behind the AXI4-Lite register wrapper or a DMA, and shares its clock/reset domain.

Parameters:
DATA_WIDTH, 32, element width in bits (>=1).
DEPTH, 8, maximum elements per frame (>=2).
SIGNED, 0, 1 = two's-complement compare; 0 = unsigned compare.

Ports:
ACLK  in  1  clock, rising edge.
ARESET  in  1  asynchronous reset, active-high.
S_AXIS_TDATA  in  DATA_WIDTH  input element.
S_AXIS_TVALID  in  1  input beat valid.
S_AXIS_TLAST  in  1  final element of frame.
S_AXIS_TREADY  out  1  core accepts input beat.
M_AXIS_TDATA  out  DATA_WIDTH  sorted element.
M_AXIS_TVALID  out  1  output beat valid.
M_AXIS_TLAST  out  1  final sorted element.
M_AXIS_TREADY  in  1  downstream accepts beat.
descending  in  1  sort order; sampled on the first accepted beat of a frame.
busy  out  1  high in SCAN, SWAP and DRAIN.
frame_len  out  $clog2(DEPTH+1)  element count of the current/last frame.

Behaviour:
- Reset (async assert, sync release): state=LOAD; count, i, j, min_idx, frame_len=0; S_AXIS_TREADY=0 during reset, 1 on the first cycle after release; M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, busy=0. Buffer contents are not cleared (don't-care).
- Reset mid-operation aborts the frame and discards its data. No partial output is produced.
- LOAD: S_AXIS_TREADY=1. Each handshake writes buf[count] and increments count. The first beat latches descending.
  - Load ends on a beat with TLAST=1 or on the DEPTH-th beat, whichever comes first. A DEPTH-th beat without TLAST is auto-terminated; TLAST on later beats is not awaited.
  - On load end, frame_len=count+1 and TREADY drops the next cycle.
  - n=1 goes to DRAIN; otherwise SCAN with i=0, j=1, min_idx=0.
- SCAN: one compare per cycle, buf[j] against buf[min_idx].
  - Ascending: update min_idx if buf[j] < buf[min_idx]. Descending: update if buf[j] > buf[min_idx].
  - The compare is strict, so ties keep the earlier index.
  - When j=n-1, go to SWAP; otherwise j++.
- SWAP: exactly one cycle, always taken, even when min_idx=i. Swaps buf[i] and buf[min_idx].
  - If i=n-2, go to DRAIN with rd=0.
  - Otherwise i++, j=i+2, min_idx=i+1, then SCAN.
- Sort latency: n(n-1)/2 SCAN cycles + (n-1) SWAP cycles. For n=8 that is 35 cycles from the cycle after the last input handshake to the first cycle of DRAIN.
- DRAIN: M_AXIS_TVALID=1 with TDATA=buf[rd]. TLAST=1 iff rd=n-1.
  - TDATA and TLAST are held stable while TVALID=1 and TREADY=0.
  - On handshake rd++. After the TLAST handshake, TVALID drops the next cycle, state=LOAD, count=0.
  - A new frame may be accepted from that cycle on.
- Input and output never overlap; single buffer, no ping-pong.
- All counters are $clog2(DEPTH) bits wide, with no wrap-around within legal ranges.
- frame_len holds its value until the next frame's load end.

Decomposition:
- Package selection_sort_pkg:
  - state enum {LOAD, SCAN, SWAP, DRAIN}.
  - IDX_W/LEN_W localparam helper functions.
  - Compare helper function cmp_better(a, b, descending, signed_mode).
- One sub-module, selection_sort_cmp: combinational strict compare parametrised by DATA_WIDTH and SIGNED, instantiated once in the datapath.
- Buffer: register array in the core. No BRAM, since SWAP needs dual write.

Test Plan:
1. DEPTH=8, asc, input 8,7,6,5,4,3,2,1 with TLAST on 1 -> output 1..8 with TLAST on 8; exactly 35 cycles between last input handshake and first TVALID; frame_len=8.
2. descending=1, input 3,9,1,9,0 (TLAST on 0) -> output 9,9,3,1,0; tie order preserved; frame_len=5; busy high only from load end to TLAST handshake.
3. Single beat 0x1234 with TLAST -> no SCAN/SWAP cycles; output 0x1234 with TLAST the cycle after load end.
4. 8 beats 0x10..0x17 with TLAST never asserted -> TREADY drops after beat 8; output 0x10..0x17 ascending, TLAST on 0x17.
5. SIGNED=1, asc, input -1,5,-8,0 (0xFFFFFFFF,5,0xFFFFFFF8,0) -> output -8,-1,0,5; with SIGNED=0 -> 0,5,0xFFFFFFF8,0xFFFFFFFF. Hold M_AXIS_TREADY low for 3 cycles per beat -> TDATA/TLAST stable, no beat lost or duplicated.
6. Assert ARESET during SCAN of a 6-element frame -> TVALID=0, busy=0 immediately; after release TREADY=1 and a new frame 2,1 (TLAST) -> output 1,2 only.

Source files
------------

// File: rtl/selection_sort_pkg.sv
// rtl/selection_sort_pkg.sv - shared types and helpers for the selection-sort stream core
package selection_sort_pkg;

    typedef enum logic [1:0] {LOAD, SCAN, SWAP, DRAIN} state_t;

    // Operands are widened to this many bits before comparing.
    localparam int CMP_W = 64;

    function automatic int idx_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int len_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // True when a must be placed ahead of b in the requested order (strict).
    function automatic logic cmp_better(input logic [CMP_W-1:0] a,
                                        input logic [CMP_W-1:0] b,
                                        input logic             descending,
                                        input logic             signed_mode);
        logic lt;
        logic gt;
        if (signed_mode) begin
            lt = $signed(a) < $signed(b);
            gt = $signed(a) > $signed(b);
        end else begin
            lt = a < b;
            gt = a > b;
        end
        return descending ? gt : lt;
    endfunction

endpackage

// File: rtl/selection_sort_cmp.sv
// rtl/selection_sort_cmp.sv - strict ordering compare of two elements
module selection_sort_cmp
    import selection_sort_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SIGNED     = 0
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  descending,
    output logic                  better
);

    localparam logic SIGNED_MODE = (SIGNED != 0);

    logic [CMP_W-1:0] a_ext;
    logic [CMP_W-1:0] b_ext;

    generate
        if (SIGNED != 0) begin : g_signed
            assign a_ext = CMP_W'($signed(a));
            assign b_ext = CMP_W'($signed(b));
        end else begin : g_unsigned
            assign a_ext = CMP_W'(a);
            assign b_ext = CMP_W'(b);
        end
    endgenerate

    assign better = cmp_better(a_ext, b_ext, descending, SIGNED_MODE);

endmodule

// File: rtl/selection_sort_stream_core.sv
// rtl/selection_sort_stream_core.sv - stream-in, sort-in-place, stream-out selection sorter
module selection_sort_stream_core
    import selection_sort_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int SIGNED     = 0
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [DATA_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic                      S_AXIS_TVALID,
    input  logic                      S_AXIS_TLAST,
    output logic                      S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic                      M_AXIS_TVALID,
    output logic                      M_AXIS_TLAST,
    input  logic                      M_AXIS_TREADY,
    input  logic                      descending,
    output logic                      busy,
    output logic [len_w(DEPTH)-1:0]   frame_len
);

    localparam int IDX_W = idx_w(DEPTH);
    localparam int LEN_W = len_w(DEPTH);

    state_t                state;
    logic [IDX_W-1:0]      count;
    logic [IDX_W-1:0]      i;
    logic [IDX_W-1:0]      j;
    logic [IDX_W-1:0]      min_idx;
    logic [IDX_W-1:0]      rd;
    logic [IDX_W-1:0]      last_idx;
    logic                  desc_q;
    logic                  tready_q;
    logic                  tvalid_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic in_hs;
    logic load_end;
    logic out_hs;
    logic better;

    assign in_hs    = S_AXIS_TVALID && tready_q;
    assign load_end = in_hs && (S_AXIS_TLAST || (count == IDX_W'(DEPTH - 1)));
    assign out_hs   = tvalid_q && M_AXIS_TREADY;

    selection_sort_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIGNED     (SIGNED)
    ) u_cmp (
        .a          (mem[j]),
        .b          (mem[min_idx]),
        .descending (desc_q),
        .better     (better)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= LOAD;
            count     <= '0;
            i         <= '0;
            j         <= '0;
            min_idx   <= '0;
            rd        <= '0;
            last_idx  <= '0;
            frame_len <= '0;
            desc_q    <= 1'b0;
            tready_q  <= 1'b0;
            tvalid_q  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    tready_q <= 1'b1;
                    if (in_hs) begin
                        if (count == '0) begin
                            desc_q <= descending;
                        end
                        if (load_end) begin
                            tready_q  <= 1'b0;
                            frame_len <= LEN_W'(count) + 1'b1;
                            last_idx  <= count;
                            count     <= '0;
                            if (count == '0) begin
                                state    <= DRAIN;
                                rd       <= '0;
                                tvalid_q <= 1'b1;
                            end else begin
                                state   <= SCAN;
                                i       <= '0;
                                j       <= IDX_W'(1);
                                min_idx <= '0;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (better) begin
                        min_idx <= j;
                    end
                    if (j == last_idx) begin
                        state <= SWAP;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                SWAP: begin
                    if (i == last_idx - 1'b1) begin
                        state    <= DRAIN;
                        rd       <= '0;
                        tvalid_q <= 1'b1;
                    end else begin
                        i       <= i + 1'b1;
                        j       <= i + IDX_W'(2);
                        min_idx <= i + 1'b1;
                        state   <= SCAN;
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (rd == last_idx) begin
                            tvalid_q <= 1'b0;
                            tready_q <= 1'b1;
                            count    <= '0;
                            state    <= LOAD;
                        end else begin
                            rd <= rd + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Buffer is never reset; it is only read after a complete load.
    always_ff @(posedge ACLK) begin
        if (state == LOAD && in_hs) begin
            mem[count] <= S_AXIS_TDATA;
        end else if (state == SWAP) begin
            mem[i]       <= mem[min_idx];
            mem[min_idx] <= mem[i];
        end
    end

    assign S_AXIS_TREADY = tready_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tvalid_q ? mem[rd] : '0;
    assign M_AXIS_TLAST  = tvalid_q && (rd == last_idx);
    assign busy          = (state != LOAD);

endmodule

// File: tb/tb_selection_sort_stream_core.sv
// tb/tb_selection_sort_stream_core.sv - self-checking bench for selection_sort_stream_core
module tb_selection_sort_stream_core;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          m_tready;
    logic          descending;

    logic          u_tready, u_tvalid, u_tlast, u_busy;
    logic [DW-1:0] u_tdata;
    logic [LW-1:0] u_len;
    logic          g_tready, g_tvalid, g_tlast, g_busy;
    logic [DW-1:0] g_tdata;
    logic [LW-1:0] g_len;

    selection_sort_stream_core #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SIGNED(0)) dut_u (
        .ACLK(clk), .ARESET(rst),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
        .S_AXIS_TREADY(u_tready),
        .M_AXIS_TDATA(u_tdata), .M_AXIS_TVALID(u_tvalid), .M_AXIS_TLAST(u_tlast),
        .M_AXIS_TREADY(m_tready),
        .descending(descending), .busy(u_busy), .frame_len(u_len)
    );

    selection_sort_stream_core #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SIGNED(1)) dut_s (
        .ACLK(clk), .ARESET(rst),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
        .S_AXIS_TREADY(g_tready),
        .M_AXIS_TDATA(g_tdata), .M_AXIS_TVALID(g_tvalid), .M_AXIS_TLAST(g_tlast),
        .M_AXIS_TREADY(m_tready),
        .descending(descending), .busy(g_busy), .frame_len(g_len)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fd    [DEPTH];
    logic [DW-1:0] exp_u [DEPTH];
    logic [DW-1:0] exp_s [DEPTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit precedes(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input bit desc, input bit sgn);
        longint ka;
        longint kb;
        ka = sgn ? longint'($signed(a)) : longint'(a);
        kb = sgn ? longint'($signed(b)) : longint'(b);
        return desc ? (ka > kb) : (ka < kb);
    endfunction

    // Reference ordering via bubble sort on plain integer keys.
    task automatic build_model(input int n, input bit desc);
        logic [DW-1:0] t;
        for (int k = 0; k < DEPTH; k++) begin
            exp_u[k] = fd[k];
            exp_s[k] = fd[k];
        end
        for (int a = 0; a < n; a++) begin
            for (int b = 0; b < n - 1 - a; b++) begin
                if (precedes(exp_u[b+1], exp_u[b], desc, 1'b0)) begin
                    t = exp_u[b]; exp_u[b] = exp_u[b+1]; exp_u[b+1] = t;
                end
                if (precedes(exp_s[b+1], exp_s[b], desc, 1'b1)) begin
                    t = exp_s[b]; exp_s[b] = exp_s[b+1]; exp_s[b+1] = t;
                end
            end
        end
    endtask

    task automatic load_frame(input int n, input bit desc, input bit no_tlast,
                              input int gap_max, input string tag, output bit ok);
        int waited;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            s_tvalid = 1'b0;
            repeat ($urandom_range(0, gap_max)) step();
            s_tvalid = 1'b1;
            s_tdata  = fd[k];
            s_tlast  = !no_tlast && (k == n - 1);
            if (k == 0) descending = desc;
            waited = 0;
            while (!(u_tready && g_tready) && waited < 50) begin
                step();
                waited++;
            end
            if (waited >= 50) begin
                chk({tag, " tready wait"}, 64'(u_tready & g_tready), 64'd1);
                ok = 1'b0;
                break;
            end
            step();
            descending = ~desc;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
    endtask

    task automatic run_frame(input int n, input bit desc, input bit no_tlast,
                             input int stall, input int gap_max, input string tag);
        bit ok;
        int hs;
        int waited;
        build_model(n, desc);
        chk({tag, " idle busy"}, 64'({u_busy, g_busy}), 64'd0);
        load_frame(n, desc, no_tlast, gap_max, tag, ok);
        if (!ok) return;
        hs = cyc;
        chk({tag, " tready drop"}, 64'({u_tready, g_tready}), 64'd0);
        chk({tag, " frame_len u"}, 64'(u_len), 64'(n));
        chk({tag, " frame_len s"}, 64'(g_len), 64'(n));
        chk({tag, " busy"}, 64'({u_busy, g_busy}), 64'd3);
        waited = 0;
        while (!u_tvalid && waited < 200) begin
            step();
            waited++;
        end
        chk({tag, " latency"}, 64'(cyc - hs), 64'(n * (n - 1) / 2 + n - 1));
        for (int k = 0; k < n; k++) begin
            for (int st = 0; st <= stall; st++) begin
                chk({tag, " tvalid"}, 64'({u_tvalid, g_tvalid}), 64'd3);
                chk({tag, " tdata u"}, 64'(u_tdata), 64'(exp_u[k]));
                chk({tag, " tdata s"}, 64'(g_tdata), 64'(exp_s[k]));
                chk({tag, " tlast"}, 64'({u_tlast, g_tlast}), (k == n - 1) ? 64'd3 : 64'd0);
                m_tready = (st == stall);
                step();
            end
            m_tready = 1'b0;
        end
        chk({tag, " end tvalid/busy"}, 64'({u_tvalid, g_tvalid, u_busy, g_busy}), 64'd0);
        chk({tag, " end tready"}, 64'({u_tready, g_tready}), 64'd3);
        chk({tag, " len hold"}, 64'(u_len), 64'(n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cycles %0d", cyc);
        $fatal(1);
    end

    initial begin
        bit ok;
        int n;
        rst = 1'b1;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_tready = 1'b0; descending = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset tready", 64'({u_tready, g_tready}), 64'd0);
        chk("reset tvalid/tlast", 64'({u_tvalid, g_tvalid, u_tlast, g_tlast}), 64'd0);
        chk("reset tdata", 64'(u_tdata | g_tdata), 64'd0);
        chk("reset busy", 64'({u_busy, g_busy}), 64'd0);
        chk("reset len", 64'({u_len, g_len}), 64'd0);
        rst = 1'b0;
        step();
        chk("release tready", 64'({u_tready, g_tready}), 64'd3);

        fd = '{32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        run_frame(8, 1'b0, 1'b0, 0, 0, "t1");

        fd = '{32'd3, 32'd9, 32'd1, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0};
        run_frame(5, 1'b1, 1'b0, 1, 1, "t2");

        fd[0] = 32'h1234;
        run_frame(1, 1'b0, 1'b0, 0, 0, "t3");

        for (int k = 0; k < DEPTH; k++) fd[k] = 32'h10 + 32'(k);
        run_frame(8, 1'b0, 1'b1, 0, 0, "t4");

        fd = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFF8, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        run_frame(4, 1'b0, 1'b0, 3, 0, "t5");

        for (int k = 0; k < DEPTH; k++) fd[k] = $urandom;
        load_frame(6, 1'b0, 1'b0, 0, "t6", ok);
        repeat (4) step();
        chk("t6 pre-reset", 64'({u_tvalid, g_tvalid, u_busy, g_busy}), 64'd3);
        rst = 1'b1;
        #1;
        chk("t6 reset outs", 64'({u_tvalid, g_tvalid, u_busy, g_busy, u_tready, g_tready}), 64'd0);
        chk("t6 reset len", 64'({u_len, g_len}), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("t6 release tready", 64'({u_tready, g_tready}), 64'd3);
        fd[0] = 32'd2;
        fd[1] = 32'd1;
        run_frame(2, 1'b0, 1'b0, 0, 0, "t6b");

        for (int r = 0; r < 16; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int k = 0; k < DEPTH; k++)
                fd[k] = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 5)) : $urandom;
            run_frame(n, 1'($urandom_range(0, 1)), (n == DEPTH) && ($urandom_range(0, 1) != 0),
                      $urandom_range(0, 2), 2, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
